wrr_arbiter: RTL and testbench

- Registered, parametrised successor to the combinational fixed-priority arbiter.
- Arbitrates NUM_PORTS requesters onto one shared resource, selectable at run time between fixed priority and weighted round robin.
- The grant is held under a grant/ack handshake, and one port may keep the grant for up to a per-port weight of back-to-back transfers.
- Sits in front of shared buses, memory ports and FIFO write muxes.

---
 rtl/wrr_arbiter.sv | 120 ++++++++++++
 tb/tb_wrr_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Registered arbiter offering fixed-priority or weighted round-robin grants.
// The grant is held under a grant/ack handshake and may burst up to a per-port weight.
module wrr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic                          mode_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
  input  logic                          ack_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic                          gnt_valid_o,
  output logic [ID_W-1:0]               gnt_id_o
);

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_PORTS-1:0] vec;
    vec = {NUM_PORTS{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] idx);
    logic [ID_W-1:0] nxt;
    nxt = (idx == ID_W'(NUM_PORTS - 1)) ? {ID_W{1'b0}} : idx + ID_W'(1);
    return nxt;
  endfunction

  logic [NUM_PORTS-1:0] gnt_r;
  logic                 valid_r;
  logic [ID_W-1:0]      cur_r;
  logic [ID_W-1:0]      ptr_r;
  logic [WEIGHT_W-1:0]  bcnt_r;

  logic [WEIGHT_W-1:0]  raw_w_s;
  logic [WEIGHT_W:0]    ew_s;
  logic [WEIGHT_W:0]    bcnt_inc_s;
  logic                 decide_s;
  logic                 burst_cont_s;
  logic [ID_W-1:0]      fp_win_s;
  logic [ID_W-1:0]      rr_win_s;
  logic [ID_W-1:0]      win_s;
  logic [ID_W-1:0]      idx_s;

  logic [NUM_PORTS-1:0] gnt_nxt_s;
  logic                 valid_nxt_s;
  logic [ID_W-1:0]      cur_nxt_s;
  logic [ID_W-1:0]      ptr_nxt_s;
  logic [WEIGHT_W-1:0]  bcnt_nxt_s;

  // Winner selection for both modes; loops run high-to-low so the lowest distance wins.
  always_comb begin
    fp_win_s = {ID_W{1'b0}};
    rr_win_s = {ID_W{1'b0}};
    idx_s    = {ID_W{1'b0}};
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      fp_win_s = req_i[i] ? ID_W'(i) : fp_win_s;
      idx_s    = ID_W'((int'(ptr_r) + i) % NUM_PORTS);
      rr_win_s = req_i[idx_s] ? idx_s : rr_win_s;
    end
    win_s = mode_i ? rr_win_s : fp_win_s;
  end

  // Decision and next-state logic; a zero weight is treated as one.
  always_comb begin
    raw_w_s      = weight_i[int'(cur_r)*WEIGHT_W +: WEIGHT_W];
    ew_s         = (raw_w_s == {WEIGHT_W{1'b0}}) ? {{WEIGHT_W{1'b0}}, 1'b1} : {1'b0, raw_w_s};
    bcnt_inc_s   = {1'b0, bcnt_r} + {{WEIGHT_W{1'b0}}, 1'b1};
    decide_s     = !valid_r || ack_i || !req_i[cur_r];
    burst_cont_s = valid_r && ack_i && mode_i && req_i[cur_r] && (bcnt_inc_s < ew_s);

    gnt_nxt_s   = gnt_r;
    valid_nxt_s = valid_r;
    cur_nxt_s   = cur_r;
    ptr_nxt_s   = ptr_r;
    bcnt_nxt_s  = bcnt_r;

    if (!decide_s) begin
      gnt_nxt_s = gnt_r;
    end else if (burst_cont_s) begin
      bcnt_nxt_s = bcnt_inc_s[WEIGHT_W-1:0];
    end else if (req_i == {NUM_PORTS{1'b0}}) begin
      gnt_nxt_s   = {NUM_PORTS{1'b0}};
      valid_nxt_s = 1'b0;
      bcnt_nxt_s  = {WEIGHT_W{1'b0}};
    end else begin
      // Pointer always advances past the winner so RR stays fair across mode switches.
      gnt_nxt_s   = onehot(win_s);
      valid_nxt_s = 1'b1;
      cur_nxt_s   = win_s;
      ptr_nxt_s   = next_index(win_s);
      bcnt_nxt_s  = {WEIGHT_W{1'b0}};
    end
  end

  // Grant state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_r   <= {NUM_PORTS{1'b0}};
      valid_r <= 1'b0;
      cur_r   <= {ID_W{1'b0}};
      ptr_r   <= {ID_W{1'b0}};
      bcnt_r  <= {WEIGHT_W{1'b0}};
    end else begin
      gnt_r   <= gnt_nxt_s;
      valid_r <= valid_nxt_s;
      cur_r   <= cur_nxt_s;
      ptr_r   <= ptr_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
    end
  end

  assign gnt_o       = gnt_r;
  assign gnt_valid_o = valid_r;
  assign gnt_id_o    = cur_r;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed table-driven bench for wrr_arbiter with hand-computed expectations.
module tb_wrr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        mode;
  logic [15:0] weight;
  logic        ack;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [1:0]  gnt_id;

  int checks;
  int passes;

  typedef struct {
    logic [3:0]  req;
    logic        mode;
    logic [15:0] weight;
    logic        ack;
    logic [3:0]  exp_gnt;
    logic        exp_valid;
    logic [1:0]  exp_id;
    string       name;
  } vec_t;

  vec_t vecs[$];

  wrr_arbiter #(.NUM_PORTS(4), .WEIGHT_W(4), .ID_W(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .mode_i     (mode),
    .weight_i   (weight),
    .ack_i      (ack),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input string name, input logic [3:0] r, input logic m, input logic [15:0] w,
                     input logic a, input logic [3:0] g, input logic v, input logic [1:0] id);
    vec_t t;
    t.req = r; t.mode = m; t.weight = w; t.ack = a;
    t.exp_gnt = g; t.exp_valid = v; t.exp_id = id; t.name = name;
    vecs.push_back(t);
  endtask

  localparam logic [15:0] W1   = 16'h1111;
  localparam logic [15:0] WMIX = 16'h2013;

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1; req = 4'b0000; mode = 1'b0; weight = W1; ack = 1'b0;

    // idle after reset
    add("idle0",  4'b0000, 1'b0, W1, 1'b0, 4'b0000, 1'b0, 2'd0);
    add("idle1",  4'b0000, 1'b0, W1, 1'b0, 4'b0000, 1'b0, 2'd0);
    // fixed priority, port 3 never wins
    for (int i = 0; i < 4; i++)
      add("fixed", 4'b1010, 1'b0, W1, 1'b1, 4'b0010, 1'b1, 2'd1);
    // plain RR from ptr=2
    add("rr2", 4'b1111, 1'b1, W1, 1'b1, 4'b0100, 1'b1, 2'd2);
    add("rr3", 4'b1111, 1'b1, W1, 1'b1, 4'b1000, 1'b1, 2'd3);
    add("rr0", 4'b1111, 1'b1, W1, 1'b1, 4'b0001, 1'b1, 2'd0);
    add("rr1", 4'b1111, 1'b1, W1, 1'b1, 4'b0010, 1'b1, 2'd1);
    add("rr2b", 4'b1111, 1'b1, W1, 1'b1, 4'b0100, 1'b1, 2'd2);
    add("rr3b", 4'b1111, 1'b1, W1, 1'b1, 4'b1000, 1'b1, 2'd3);
    // weighted: p0=3 p1=1 p2=0 p3=2; port 3 continues its burst first
    add("wrr3a", 4'b1111, 1'b1, WMIX, 1'b1, 4'b1000, 1'b1, 2'd3);
    add("wrr0a", 4'b1111, 1'b1, WMIX, 1'b1, 4'b0001, 1'b1, 2'd0);
    add("wrr0b", 4'b1111, 1'b1, WMIX, 1'b1, 4'b0001, 1'b1, 2'd0);
    add("wrr0c", 4'b1111, 1'b1, WMIX, 1'b1, 4'b0001, 1'b1, 2'd0);
    add("wrr1",  4'b1111, 1'b1, WMIX, 1'b1, 4'b0010, 1'b1, 2'd1);
    add("wrr2",  4'b1111, 1'b1, WMIX, 1'b1, 4'b0100, 1'b1, 2'd2);
    add("wrr3b", 4'b1111, 1'b1, WMIX, 1'b1, 4'b1000, 1'b1, 2'd3);
    add("wrr3c", 4'b1111, 1'b1, WMIX, 1'b1, 4'b1000, 1'b1, 2'd3);
    add("wrr0d", 4'b1111, 1'b1, WMIX, 1'b1, 4'b0001, 1'b1, 2'd0);
    add("wrr0e", 4'b1111, 1'b1, WMIX, 1'b1, 4'b0001, 1'b1, 2'd0);
    // hold without ack, then revocation
    for (int i = 0; i < 6; i++)
      add("hold", 4'b0100, 1'b1, W1, 1'b0, 4'b0100, 1'b1, 2'd2);
    add("revoke0", 4'b0001, 1'b1, W1, 1'b0, 4'b0001, 1'b1, 2'd0);
    add("revoke1", 4'b0010, 1'b1, W1, 1'b0, 4'b0010, 1'b1, 2'd1);
    add("idle_id", 4'b0000, 1'b1, W1, 1'b0, 4'b0000, 1'b0, 2'd1);
    add("ack_idle", 4'b0000, 1'b1, W1, 1'b1, 4'b0000, 1'b0, 2'd1);
    // mode change does not disturb a held grant
    add("mode_fp",   4'b1100, 1'b0, W1, 1'b0, 4'b0100, 1'b1, 2'd2);
    add("mode_hold", 4'b1101, 1'b1, W1, 1'b0, 4'b0100, 1'b1, 2'd2);
    add("mode_rr",   4'b1101, 1'b1, W1, 1'b1, 4'b1000, 1'b1, 2'd3);
    // weight drops mid-burst
    add("wchg_a", 4'b1000, 1'b1, 16'h3111, 1'b1, 4'b1000, 1'b1, 2'd3);
    add("wchg_b", 4'b1001, 1'b1, 16'h1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    // sole requester wrap, no bubble at burst boundary
    for (int i = 0; i < 5; i++)
      add("sole3", 4'b1000, 1'b1, 16'h2111, 1'b1, 4'b1000, 1'b1, 2'd3);

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {28'd0, gnt, gnt_valid, gnt_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req = vecs[i].req; mode = vecs[i].mode; weight = vecs[i].weight; ack = vecs[i].ack;
      @(posedge clk);
      #1;
      check(vecs[i].name, {25'd0, gnt, gnt_valid, gnt_id},
            {25'd0, vecs[i].exp_gnt, vecs[i].exp_valid, vecs[i].exp_id});
      check("valid_inv", {31'd0, gnt_valid}, {31'd0, |gnt});
    end

    // move ptr away from 0, then reset mid-grant
    @(negedge clk);
    req = 4'b0010; mode = 1'b1; weight = W1; ack = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst", {28'd0, gnt, gnt_valid, gnt_id}, {28'd0, 4'b0010, 1'b1, 2'd1});
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", {28'd0, gnt, gnt_valid, gnt_id}, 32'd0);
    req = 4'b0000; ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", {28'd0, gnt, gnt_valid, gnt_id}, 32'd0);
    @(negedge clk);
    req = 4'b1001;
    #1;
    check("latency_pre", {28'd0, gnt, gnt_valid, gnt_id}, 32'd0);
    @(posedge clk);
    #1;
    check("ptr_reset", {28'd0, gnt, gnt_valid, gnt_id}, {28'd0, 4'b0001, 1'b1, 2'd0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
